// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with a valid/ready handshake.
// A main output register plus one skid entry keeps 1 instr/cycle flowing
// under backpressure without a combinational out_ready -> in_ready path.
//
// state    | meaning
// ---------+------------------------------------------------------------
// EMPTY    | nothing held, out_valid=0, in_ready=1
// ONE      | main register holds one decoded instr, in_ready=1
// FULL     | main and skid both hold instrs (skid is younger), in_ready=0
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int PC_W        = 12,
    parameter int RA_REG      = 31,
    parameter int STATUS_REG  = 30,
    parameter int NUM_ALU_OPS = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_shamt,
    output logic [4:0]      out_alu_op,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_type,
    output logic            out_writes_rd,
    output logic            out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_JR   = 5'b00100;

    localparam logic [1:0] TYPE_R   = 2'd0;
    localparam logic [1:0] TYPE_I   = 2'd1;
    localparam logic [1:0] TYPE_JI  = 2'd2;
    localparam logic [1:0] TYPE_JII = 2'd3;

    localparam logic [4:0] RA_IDX     = 5'(RA_REG);
    localparam logic [4:0] STATUS_IDX = 5'(STATUS_REG);
    localparam logic [5:0] ALU_LIMIT  = 6'(NUM_ALU_OPS);

    typedef struct packed {
        logic [4:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      shamt;
        logic [4:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [PC_W-1:0] pc;
        logic [1:0]      itype;
        logic            writes_rd;
        logic            illegal;
    } dec_t;

    logic [1:0] state;
    dec_t       dec;
    dec_t       main_q;
    dec_t       skid_q;
    logic       accept;
    logic       pop;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Input-side decode: field slicing, implicit registers, classification.
    always_comb begin
        dec           = '0;
        dec.opcode    = in_instr[31:27];
        dec.rd        = in_instr[26:22];
        dec.rs        = in_instr[21:17];
        dec.rt        = in_instr[16:12];
        dec.shamt     = in_instr[11:7];
        dec.alu_op    = in_instr[6:2];
        dec.imm       = {{(XLEN-17){in_instr[16]}}, in_instr[16:0]};
        dec.target    = {{(XLEN-27){1'b0}}, in_instr[26:0]};
        dec.pc        = in_pc;
        dec.itype     = TYPE_R;
        dec.writes_rd = 1'b0;
        dec.illegal   = 1'b0;
        case (in_instr[31:27])
            OP_R: begin
                if ({1'b0, in_instr[6:2]} < ALU_LIMIT) begin
                    dec.writes_rd = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_ADDI, OP_LW: begin
                dec.itype     = TYPE_I;
                dec.writes_rd = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                dec.itype = TYPE_I;
            end
            OP_J: begin
                dec.itype = TYPE_JI;
            end
            OP_JAL: begin
                dec.itype     = TYPE_JI;
                dec.rd        = RA_IDX;
                dec.writes_rd = 1'b1;
            end
            OP_SETX: begin
                dec.itype     = TYPE_JI;
                dec.rd        = STATUS_IDX;
                dec.writes_rd = 1'b1;
            end
            OP_BEX: begin
                dec.itype = TYPE_JI;
                dec.rs    = STATUS_IDX;
            end
            OP_JR: begin
                dec.itype = TYPE_JII;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Occupancy FSM and main/skid registers; flush empties but leaves the
    // last field values in place so the outputs do not toggle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q <= dec;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_q <= dec;
                    end else if (accept) begin
                        skid_q <= dec;
                        state  <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_opcode    = main_q.opcode;
    assign out_rd        = main_q.rd;
    assign out_rs        = main_q.rs;
    assign out_rt        = main_q.rt;
    assign out_shamt     = main_q.shamt;
    assign out_alu_op    = main_q.alu_op;
    assign out_imm       = main_q.imm;
    assign out_target    = main_q.target;
    assign out_pc        = main_q.pc;
    assign out_type      = main_q.itype;
    assign out_writes_rd = main_q.writes_rd;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: decode vector table, backpressure ordering,
// flush, and a random-backpressure stream with a reset in the middle.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [11:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode, out_rd, out_rs, out_rt, out_shamt, out_alu_op;
    logic [31:0] out_imm, out_target;
    logic [11:0] out_pc;
    logic [1:0]  out_type;
    logic        out_writes_rd, out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs),
        .out_rt(out_rt), .out_shamt(out_shamt), .out_alu_op(out_alu_op),
        .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
        .out_type(out_type), .out_writes_rd(out_writes_rd),
        .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [11:0] pc;
        logic [4:0]  op, rd, rs, rt, shamt, alu;
        logic [31:0] imm, target;
        logic [1:0]  typ;
        logic        wr, ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [11:0] pc,
        input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] shamt, input logic [4:0] alu,
        input logic [31:0] imm, input logic [31:0] target,
        input logic [1:0] typ, input logic wr, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.op = op; v.rd = rd; v.rs = rs;
        v.rt = rt; v.shamt = shamt; v.alu = alu; v.imm = imm;
        v.target = target; v.typ = typ; v.wr = wr; v.ill = ill;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [11:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [11:0] sb[$];
    logic [11:0] exp_pc;
    logic [11:0] next_pc;
    int          pops;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             instr         pc     op     rd  rs  rt  sh  alu imm           target        typ wr ill
        vecs[0]  = mk(32'h28C3FFFB, 12'h010, 5'd5,  3,  1,  31, 31, 30, 32'hFFFFFFFB, 32'h00C3FFFB, 1, 1, 0); // addi r3,r1,-5
        vecs[1]  = mk(32'h18000123, 12'h014, 5'd3,  31, 0,  0,  2,  8,  32'h00000123, 32'h00000123, 2, 1, 0); // jal
        vecs[2]  = mk(32'h00886004, 12'h018, 5'd0,  2,  4,  6,  0,  1,  32'h00006004, 32'h00886004, 0, 1, 0); // R alu 1
        vecs[3]  = mk(32'h00886018, 12'h01C, 5'd0,  2,  4,  6,  0,  6,  32'h00006018, 32'h00886018, 0, 0, 1); // R alu 6 illegal
        vecs[4]  = mk(32'h00886014, 12'h020, 5'd0,  2,  4,  6,  0,  5,  32'h00006014, 32'h00886014, 0, 1, 0); // R alu 5 last legal
        vecs[5]  = mk(32'hF8000000, 12'h024, 5'd31, 0,  0,  0,  0,  0,  32'h00000000, 32'h00000000, 0, 0, 1); // opcode 11111
        vecs[6]  = mk(32'hA8001234, 12'h028, 5'd21, 30, 0,  1,  4,  13, 32'h00001234, 32'h00001234, 2, 1, 0); // setx
        vecs[7]  = mk(32'hB0000040, 12'h02C, 5'd22, 0,  30, 0,  0,  16, 32'h00000040, 32'h00000040, 2, 0, 0); // bex
        vecs[8]  = mk(32'h21400000, 12'h030, 5'd4,  5,  0,  0,  0,  0,  32'h00000000, 32'h01400000, 3, 0, 0); // jr r5
        vecs[9]  = mk(32'h39C40010, 12'h034, 5'd7,  7,  2,  0,  0,  4,  32'h00000010, 32'h01C40010, 1, 0, 0); // sw
        vecs[10] = mk(32'h4206FFFF, 12'h038, 5'd8,  8,  3,  15, 31, 31, 32'h0000FFFF, 32'h0206FFFF, 1, 1, 0); // lw, max positive imm
        vecs[11] = mk(32'h10010000, 12'h03C, 5'd2,  0,  0,  16, 0,  0,  32'hFFFF0000, 32'h00010000, 1, 0, 0); // bne, min negative imm
        vecs[12] = mk(32'h30000000, 12'h040, 5'd6,  0,  0,  0,  0,  0,  32'h00000000, 32'h00000000, 1, 0, 0); // blt
        vecs[13] = mk(32'h08000ABC, 12'hFFF, 5'd1,  0,  0,  0,  21, 15, 32'h00000ABC, 32'h00000ABC, 2, 0, 0); // j, pc max
        vecs[14] = mk(32'h48000000, 12'h048, 5'd9,  0,  0,  0,  0,  0,  32'h00000000, 32'h00000000, 0, 0, 1); // opcode 01001

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 12'h0);
        repeat (3) @(negedge clock);

        // reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("rst_pc",        {20'b0, out_pc}, 32'd0);
        chk("rst_imm",       out_imm, 32'd0);
        chk("rst_target",    out_target, 32'd0);
        chk("rst_rd",        {27'b0, out_rd}, 32'd0);
        chk("rst_flags",     {28'b0, out_type, out_writes_rd, out_illegal}, 32'd0);
        reset = 1'b0;

        // decode table, streamed at 1/cycle with out_ready=1
        out_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc);
            @(negedge clock);
            chk($sformatf("v%0d_valid", i),  {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_opcode", i), {27'b0, out_opcode}, {27'b0, vecs[i].op});
            chk($sformatf("v%0d_rd", i),     {27'b0, out_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_rs", i),     {27'b0, out_rs}, {27'b0, vecs[i].rs});
            chk($sformatf("v%0d_rt", i),     {27'b0, out_rt}, {27'b0, vecs[i].rt});
            chk($sformatf("v%0d_shamt", i),  {27'b0, out_shamt}, {27'b0, vecs[i].shamt});
            chk($sformatf("v%0d_alu_op", i), {27'b0, out_alu_op}, {27'b0, vecs[i].alu});
            chk($sformatf("v%0d_imm", i),    out_imm, vecs[i].imm);
            chk($sformatf("v%0d_target", i), out_target, vecs[i].target);
            chk($sformatf("v%0d_pc", i),     {20'b0, out_pc}, {20'b0, vecs[i].pc});
            chk($sformatf("v%0d_type", i),   {30'b0, out_type}, {30'b0, vecs[i].typ});
            chk($sformatf("v%0d_wr", i),     {31'b0, out_writes_rd}, {31'b0, vecs[i].wr});
            chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
        end
        drive(1'b0, 32'h0, 12'h0);
        @(negedge clock);
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: A,B accepted, C held off, then A,B,C in order
        out_ready = 1'b0;
        drive(1'b1, 32'h28C3FFFB, 12'h100);           // A: addi, rd 3
        @(negedge clock);
        chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_one_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h18000123, 12'h104);           // B: jal, rd 31
        @(negedge clock);
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_a_pc", {20'b0, out_pc}, 32'h100);
        drive(1'b1, 32'h00886004, 12'h108);           // C: R, rd 2
        @(negedge clock);
        chk("bp_hold_pc", {20'b0, out_pc}, 32'h100);
        chk("bp_hold_rd", {27'b0, out_rd}, 32'd3);
        chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_b_pc", {20'b0, out_pc}, 32'h104);
        chk("bp_b_rd", {27'b0, out_rd}, 32'd31);
        chk("bp_b_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clock);
        chk("bp_c_pc", {20'b0, out_pc}, 32'h108);
        chk("bp_c_rd", {27'b0, out_rd}, 32'd2);
        chk("bp_c_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 12'h0);
        @(negedge clock);
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // flush while FULL with a new instr offered
        out_ready = 1'b0;
        drive(1'b1, 32'h00886004, 12'h0A1);
        @(negedge clock);
        drive(1'b1, 32'h00886004, 12'h0B2);
        @(negedge clock);
        chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h18000123, 12'h0D4);
        @(negedge clock);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 12'h0);
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 32'h39C40010, 12'h0E5);
        @(negedge clock);
        chk("fl_next_pc", {20'b0, out_pc}, 32'h0E5);
        drive(1'b0, 32'h0, 12'h0);
        @(negedge clock);
        chk("fl_next_gone", {31'b0, out_valid}, 32'd0);

        // random backpressure stream with scoreboard, reset mid-stream
        next_pc = 12'h200;
        pops = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            drive($urandom_range(0, 3) != 0, 32'h28C00000 | {20'b0, next_pc}, next_pc);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", {20'b0, out_pc}, 32'hFFFFFFFF);
                end else begin
                    exp_pc = sb.pop_front();
                    chk("sb_pc", {20'b0, out_pc}, {20'b0, exp_pc});
                    chk("sb_imm", out_imm, {20'b0, exp_pc});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_pc);
                next_pc = next_pc + 12'd1;
            end
        end
        chk("sb_pops_nonzero", {31'b0, pops > 20}, 32'd1);
        chk("sb_backlog", {31'b0, sb.size() <= 2}, 32'd1);

        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 32'h18000123, 12'h3FF);
        @(negedge clock);
        chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mr_pc", {20'b0, out_pc}, 32'd0);
        chk("mr_imm", out_imm, 32'd0);
        chk("mr_target", out_target, 32'd0);
        chk("mr_fields", {7'b0, out_opcode, out_rd, out_rs, out_rt, out_shamt}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 12'h0);
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("mr_no_leftover", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
